// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-port RAM slave with byte selects, base-address decode,
// error response on out-of-range accesses and a configurable number of wait states.
module wb_ram_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [DATA_W/8-1:0] i_wb_sel,
  input  logic [ADDR_W-1:0]   i_wb_adr,
  input  logic [DATA_W-1:0]   i_wb_dat,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  output logic                o_busy
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                go_resp;
  logic                req;

  logic [ADDR_W-1:0]   adr_off;
  logic [ADDR_W-1:0]   idx_full;
  logic                rng_in;
  logic [IDX_W-1:0]    idx_in;

  logic                we_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [DATA_W-1:0]   dat_p0;
  logic                rng_p0;

  logic                eff_we;
  logic [SEL_W-1:0]    eff_sel;
  logic [IDX_W-1:0]    eff_idx;
  logic [DATA_W-1:0]   eff_dat;
  logic                eff_rng;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign req      = i_wb_cyc & i_wb_stb;
  assign adr_off  = i_wb_adr - BASE_ADDR;
  assign idx_full = adr_off >> OFF_W;
  assign rng_in   = (i_wb_adr >= BASE_ADDR) && (idx_full < ADDR_W'(DEPTH));
  assign idx_in   = idx_full[IDX_W-1:0];
  assign o_busy   = (state != IDLE);

  // With no wait states RESP is entered on the accepting edge, so the live bus
  // request drives the commit; otherwise the latched copy does.
  always_comb begin
    eff_we  = we_p0;
    eff_sel = sel_p0;
    eff_idx = idx_p0;
    eff_dat = dat_p0;
    eff_rng = rng_p0;
    if (state == IDLE) begin
      eff_we  = i_wb_we;
      eff_sel = i_wb_sel;
      eff_idx = idx_in;
      eff_dat = i_wb_dat;
      eff_rng = rng_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_STATES - 1);
          end else begin
            state_n = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          state_n = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_wb_ack <= go_resp & eff_rng;
      o_wb_err <= go_resp & ~eff_rng;
      if (go_resp && eff_rng && !eff_we) o_wb_dat <= mem[eff_idx];
    end
  end

  // p0: request captured on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0  <= i_wb_we;
      sel_p0 <= i_wb_sel;
      idx_p0 <= idx_in;
      dat_p0 <= i_wb_dat;
      rng_p0 <= rng_in;
    end
  end

  always_ff @(posedge clk) begin
    if (go_resp && eff_rng && eff_we && !rst) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (eff_sel[b]) mem[eff_idx][8*b +: 8] <= eff_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: three instances (plain, offset base, wait states)
// driven from a vector table plus hand-written abort/reset/back-to-back sequences.
module tb_wb_ram_slave;

  logic        clk;
  logic        rst;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  sel  [3];
  logic [31:0] adr  [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];
  logic        busy [3];

  int ws [3] = '{0, 0, 3};

  typedef struct {
    int          d;
    logic        is_err;
    logic [31:0] exp_dat;
  } sb_rec_t;

  typedef struct {
    int          d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        is_err;
    logic [31:0] rd;
  } vec_t;

  sb_rec_t     sb [$];
  sb_rec_t     mon_r;
  vec_t        vecs [$];
  logic [31:0] last_rd [3];
  int          n_checks = 0;
  int          n_fail   = 0;

  wb_ram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_sel(sel[0]), .i_wb_adr(adr[0]), .i_wb_dat(wdat[0]), .o_wb_dat(rdat[0]),
    .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_busy(busy[0]));

  wb_ram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h100), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_sel(sel[1]), .i_wb_adr(adr[1]), .i_wb_dat(wdat[1]), .o_wb_dat(rdat[1]),
    .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_busy(busy[1]));

  wb_ram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
    .i_wb_sel(sel[2]), .i_wb_adr(adr[2]), .i_wb_dat(wdat[2]), .o_wb_dat(rdat[2]),
    .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Scoreboard consumer: every ack/err must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: dut %0d ack=%b err=%b with nothing outstanding", d, ack[d], err[d]);
        end else begin
          mon_r = sb.pop_front();
          check("resp_dut", 32'(d), 32'(mon_r.d));
          check("resp_err", {31'b0, err[d]}, {31'b0, mon_r.is_err});
          check("resp_ack", {31'b0, ack[d]}, {31'b0, !mon_r.is_err});
          check("resp_dat", rdat[d], mon_r.exp_dat);
        end
      end
    end
  end

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
    end
  endtask

  task automatic wait_resp(input int d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] === 1'b1 || err[d] === 1'b1) && n < 40);
  endtask

  task automatic push_exp(input int d, input logic w, input logic is_err, input logic [31:0] rd);
    sb_rec_t r;
    r.d      = d;
    r.is_err = is_err;
    r.exp_dat = (!is_err && !w) ? rd : last_rd[d];
    if (!is_err && !w) last_rd[d] = rd;
    sb.push_back(r);
  endtask

  task automatic do_req(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] dt, input logic is_err, input logic [31:0] rd);
    int n;
    push_exp(d, w, is_err, rd);
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = dt;
    wait_resp(d, n);
    check("latency", 32'(n), 32'(ws[d] + 2));
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic count_resp(input int d, input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1 || err[d] === 1'b1) hits++;
    end
  endtask

  initial begin
    int n;
    int hits;
    idle_all();
    for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;

    // Reset with a request pending: rst must win and outputs stay at reset values.
    rst = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'h10; wdat[0] = 32'h5555AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ack",  {31'b0, ack[0]},  32'h0);
      check("rst_err",  {31'b0, err[0]},  32'h0);
      check("rst_busy", {31'b0, busy[0]}, 32'h0);
      check("rst_dat",  rdat[0],          32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();
    count_resp(0, 2, hits);
    check("post_rst_no_ack", 32'(hits), 32'h0);
    check("post_rst_busy", {31'b0, busy[0]}, 32'h0);

    vecs.push_back('{0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h13, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h00, 32'h11223344, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 4'h5, 32'h00, 32'hAABBCCDD, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h00, 32'h0,        1'b0, 32'h11BB33DD});
    vecs.push_back('{0, 1'b1, 4'h0, 32'h00, 32'hFFFFFFFF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 4'h0, 32'h02, 32'h0,        1'b0, 32'h11BB33DD});
    vecs.push_back('{0, 1'b0, 4'h1, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h40, 32'hA0A0A0A0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h44, 32'hB1B1B1B1, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h48, 32'hC2C2C2C2, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h4C, 32'hD3D3D3D3, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 4'hF, 32'h100, 32'hCAFE0001, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h100, 32'h0,        1'b0, 32'hCAFE0001});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h0FC, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h200, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1, 1'b1, 4'hF, 32'h200, 32'hBAD0BAD0, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b1, 4'hF, 32'h1FC, 32'h55AA55AA, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h1FC, 32'h0,        1'b0, 32'h55AA55AA});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h100, 32'h0,        1'b0, 32'hCAFE0001});
    vecs.push_back('{2, 1'b1, 4'hF, 32'h20, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{2, 1'b0, 4'hF, 32'h20, 32'h0,        1'b0, 32'h12345678});

    foreach (vecs[i])
      do_req(vecs[i].d, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].is_err, vecs[i].rd);

    // Abort: drop cyc while waiting; the write must not land and no response appears.
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h20; wdat[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy[2]}, 32'h1);
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    count_resp(2, 8, hits);
    check("abort_no_resp", 32'(hits), 32'h0);
    check("abort_idle", {31'b0, busy[2]}, 32'h0);
    do_req(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h12345678);

    // Reset during WAIT drops the pending write.
    do_req(2, 1'b1, 4'hF, 32'h24, 32'h0F0F0F0F, 1'b0, 32'h0);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h24; wdat[2] = 32'hFFFF0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
    count_resp(2, 8, hits);
    check("rst_wait_no_resp", 32'(hits), 32'h0);
    check("rst_wait_busy", {31'b0, busy[2]}, 32'h0);
    check("rst_wait_dat_cleared", rdat[2], 32'h0);
    do_req(2, 1'b0, 4'hF, 32'h24, 32'h0, 1'b0, 32'h0F0F0F0F);

    // Back-to-back reads with stb held: one ack every two cycles.
    push_exp(0, 1'b0, 1'b0, 32'hA0A0A0A0);
    push_exp(0, 1'b0, 1'b0, 32'hB1B1B1B1);
    push_exp(0, 1'b0, 1'b0, 32'hC2C2C2C2);
    push_exp(0, 1'b0, 1'b0, 32'hD3D3D3D3);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      wait_resp(0, n);
      check("b2b_spacing", 32'(n), 32'd2);
      @(posedge clk); #1;
      if (i < 3) adr[0] = 32'h40 + 32'(4 * (i + 1));
      else begin
        cyc[0] = 1'b0; stb[0] = 1'b0;
      end
    end
    count_resp(0, 3, hits);
    check("b2b_no_extra", 32'(hits), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
